// File: rtl/magnitude_sqrt_unit_pkg.sv
// Shared definitions for the magnitude square-root engine.
//   WIDTH   : default operand width (sum of squares from the magnitude stage)
//   state_e : controller state encoding (IDLE, CALC)
package magnitude_sqrt_unit_pkg;

  localparam int WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

endpackage

// File: rtl/magnitude_sqrt_unit_sqrt_step.sv
// One step of the restoring digit-by-digit square root.
// Ports:
//   acc      : partial remainder (H+2 bits)
//   rad_top  : next two radicand bits, MSB first
//   root     : partial root (H bits)
//   acc_nxt  : remainder after this step
//   root_nxt : root with the new bit shifted in
module sqrt_step #(
  parameter int H = 16
) (
  input  logic [H+1:0] acc,
  input  logic [1:0]   rad_top,
  input  logic [H-1:0] root,
  output logic [H+1:0] acc_nxt,
  output logic [H-1:0] root_nxt
);

  logic [H+1:0] t_lo;
  logic [H+1:0] trial;
  logic         ge;

  // The comparison uses the full-width shifted remainder; the subtraction
  // only needs H+2 bits because a successful trial always leaves a result
  // that fits the accumulator.
  assign trial = {root, 2'b01};
  assign t_lo  = {acc[H-1:0], rad_top};
  assign ge    = {acc, rad_top} >= {2'b00, trial};

  always_comb begin
    acc_nxt  = t_lo;
    root_nxt = {root[H-2:0], 1'b0};
    if (ge) begin
      acc_nxt  = t_lo - trial;
      root_nxt = {root[H-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/magnitude_sqrt_unit.sv
// Iterative integer square root: R = floor(sqrt(M)), Rem = M - R^2.
// One root bit per clock; fixed latency of Width/2 clocks from accept.
// Handshake: in IDLE an edge with start=1 accepts M (busy rises); start while
// busy is ignored. valid pulses for one cycle when R/Rem update, in the same
// cycle busy is low again, so start may be held high for back-to-back work.
// Ports:
//   Clk, Rst  : clock, asynchronous active-low reset
//   start, M  : request and operand
//   R, Rem    : root and remainder (held until next completion)
//   busy      : computation in progress
//   valid     : one-cycle result strobe
//   dbg_state : current controller state
module magnitude_sqrt_unit
  import magnitude_sqrt_unit_pkg::*;
#(
  parameter int Width = WIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [Width-1:0]     M,
  output logic [Width/2-1:0]   R,
  output logic [Width/2:0]     Rem,
  output logic                 busy,
  output logic                 valid,
  output state_e               dbg_state
);

  localparam int H  = Width / 2;
  localparam int CW = $clog2(H + 1);

  state_e         state, state_nxt;
  logic [Width-1:0] rad, rad_nxt;
  logic [H+1:0]   acc, acc_nxt;
  logic [H-1:0]   root, root_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [H-1:0]   r_nxt;
  logic [H:0]     rem_nxt;
  logic           busy_nxt, valid_nxt;

  logic [H+1:0]   step_acc;
  logic [H-1:0]   step_root;

  sqrt_step #(.H(H)) u_step (
    .acc      (acc),
    .rad_top  (rad[Width-1:Width-2]),
    .root     (root),
    .acc_nxt  (step_acc),
    .root_nxt (step_root)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      rad   <= '0;
      acc   <= '0;
      root  <= '0;
      cnt   <= '0;
      R     <= '0;
      Rem   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      rad   <= rad_nxt;
      acc   <= acc_nxt;
      root  <= root_nxt;
      cnt   <= cnt_nxt;
      R     <= r_nxt;
      Rem   <= rem_nxt;
      busy  <= busy_nxt;
      valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rad_nxt   = rad;
    acc_nxt   = acc;
    root_nxt  = root;
    cnt_nxt   = cnt;
    r_nxt     = R;
    rem_nxt   = Rem;
    busy_nxt  = busy;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          rad_nxt   = M;
          acc_nxt   = '0;
          root_nxt  = '0;
          cnt_nxt   = CW'(H);
          busy_nxt  = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        rad_nxt  = {rad[Width-3:0], 2'b00};
        acc_nxt  = step_acc;
        root_nxt = step_root;
        cnt_nxt  = cnt - CW'(1);
        // Last step: publish the result and free the engine in the same edge.
        if (cnt == CW'(1)) begin
          r_nxt     = step_root;
          rem_nxt   = step_acc[H:0];
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_magnitude_sqrt_unit.sv
// Bench for magnitude_sqrt_unit: reset/idle checks, table of directed
// vectors, back-to-back and mid-operation reset sequences, random sweep.
module tb_magnitude_sqrt_unit;
  import magnitude_sqrt_unit_pkg::*;

  localparam int W = 32;
  localparam int H = W / 2;
  localparam int LAT = H;

  // ---------------- clock / reset ----------------
  logic         Clk;
  logic         Rst;
  logic         start;
  logic [W-1:0] M;
  logic [H-1:0] R;
  logic [H:0]   Rem;
  logic         busy;
  logic         valid;
  state_e       dbg_state;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  magnitude_sqrt_unit #(.Width(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .M         (M),
    .R         (R),
    .Rem       (Rem),
    .busy      (busy),
    .valid     (valid),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [H+H:0] exp_q[$];   // {R, Rem}
  int           acc_q[$];   // expected accept cycle of each queued result
  logic         prev_valid = 1'b0;

  always @(posedge Clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [H+H:0] ref_model(input logic [W-1:0] m);
    longint r;
    longint mm;
    mm = longint'(m);
    r = longint'($sqrt(real'(mm)));
    while (r * r > mm) r--;
    while ((r + 1) * (r + 1) <= mm) r++;
    return {r[H-1:0], 17'(mm - r * r)};
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge Clk) begin
    logic [H+H:0] e;
    int a;
    chk("busy_valid_exclusive", 64'(busy && valid), 64'd0);
    chk("valid_pulse_width", 64'(valid && prev_valid), 64'd0);
    prev_valid = valid;
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 64'(valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("R", 64'(R), 64'(e[H+H:H+1]));
        chk("Rem", 64'(Rem), 64'(e[H:0]));
        if (acc_q.size() != 0) begin
          a = acc_q.pop_front();
          chk("latency", 64'(cyc), 64'(a + LAT));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge Clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      chk("result_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] m, input logic [H+H:0] exp);
    @(negedge Clk);
    start = 1'b1;
    M = m;
    exp_q.push_back(exp);
    @(posedge Clk);
    #1;
    acc_q.push_back(cyc);
    chk("busy_after_accept", 64'(busy), 64'd1);
    start = 1'b0;
    M = $urandom();   // must not affect the running computation
    wait_drain(LAT + 8);
  endtask

  typedef struct {
    logic [W-1:0] m;
    logic [H-1:0] r;
    logic [H:0]   rem;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0;
    start = 1'b0;
    M = '0;

    // Reset with start toggling: everything stays at zero.
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      start = ~start;
      M = $urandom();
      #1;
      chk("rst_R", 64'(R), 64'd0);
      chk("rst_Rem", 64'(Rem), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
    end
    @(negedge Clk);
    start = 1'b0;
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    chk("idle_state", 64'(dbg_state), 64'(IDLE));

    // Directed vectors.
    vecs[0] = '{32'd0,          16'd0,      17'd0};
    vecs[1] = '{32'd25,         16'd5,      17'd0};
    vecs[2] = '{32'd26,         16'd5,      17'd1};
    vecs[3] = '{32'd3,          16'd1,      17'd2};
    vecs[4] = '{32'h0001_0000,  16'h0100,   17'd0};
    vecs[5] = '{32'hFFFF_FFFF,  16'hFFFF,   17'h1FFFE};
    vecs[6] = '{32'd1000,       16'd31,     17'd39};
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].m, {vecs[i].r, vecs[i].rem});
    end

    // Results are held while idle.
    repeat (3) @(negedge Clk);
    chk("hold_R", 64'(R), 64'd31);
    chk("hold_Rem", 64'(Rem), 64'd39);

    // Back-to-back with start held high; M=9 shown while busy is ignored.
    @(negedge Clk);
    start = 1'b1;
    M = 32'd100;
    exp_q.push_back({16'd10, 17'd0});
    exp_q.push_back({16'd12, 17'd0});
    @(posedge Clk);
    #1;
    acc_q.push_back(cyc);
    acc_q.push_back(cyc + LAT + 1);
    M = 32'd9;
    repeat (8) @(posedge Clk);
    #1;
    M = 32'd144;
    repeat (LAT + 1 - 8) @(posedge Clk);   // second accept edge
    #1;
    chk("b2b_busy", 64'(busy), 64'd1);
    start = 1'b0;
    M = 32'd9;
    wait_drain(LAT + 8);
    repeat (3) @(negedge Clk);
    chk("b2b_no_third", 64'(busy), 64'd0);

    // Reset in the middle of a computation.
    @(negedge Clk);
    start = 1'b1;
    M = 32'd1000;
    @(posedge Clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    chk("abort_R", 64'(R), 64'd0);
    chk("abort_Rem", 64'(Rem), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'(IDLE));
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (LAT + 4) @(negedge Clk);   // monitor flags any late valid
    chk("abort_no_busy", 64'(busy), 64'd0);
    run_op(32'd1000, {16'd31, 17'd39});

    // Random sweep against the reference model.
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] m;
      case ($urandom_range(0, 9))
        0:       m = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        1:       m = 32'($urandom_range(0, 1024));
        default: m = $urandom();
      endcase
      run_op(m, ref_model(m));
    end

    repeat (4) @(negedge Clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
